// File: rtl/dbus_pkg.sv
// Shared definitions for the two-master data-bus arbiter.
// Holds the FSM state encoding, the master-id type and its constants,
// the default bus widths, and the decode-error helper used by the
// response path.
package dbus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef logic mid_t;

  localparam mid_t M0 = 1'b0;  // core D-port
  localparam mid_t M1 = 1'b1;  // loader

  // A transaction is a decode error when no slave or more than one slave
  // claimed the address.
  function automatic logic decode_err(input logic sel0, input logic sel1);
    return (sel0 == sel1);
  endfunction

endpackage

// File: rtl/dbus_arbiter_if.sv
// Bundle of all master-side and shared-bus signals of the arbiter.
//   slave  : arbiter view (takes master requests and slave responses,
//            drives grants/acks and the shared bus)
//   master : environment view (masters plus slaves), the mirror image
// Per master X in {0,1}: mX_req, mX_we, mX_addr, mX_wdata in;
//   mX_gnt, mX_ack, mX_err, mX_rdata out.
// Shared bus: s_addr, s_wdata, s_wen, s_ren out; s0_sel, s1_sel,
//   s0_rdata, s1_rdata in.
interface dbus_arbiter_if
  import dbus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_ack;
  logic              m0_err;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_ack;
  logic              m1_err;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic              s_wen;
  logic              s_ren;
  logic              s0_sel;
  logic              s1_sel;
  logic [DATA_W-1:0] s0_rdata;
  logic [DATA_W-1:0] s1_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m0_gnt, m0_ack, m0_err, m0_rdata,
    output m1_gnt, m1_ack, m1_err, m1_rdata,
    output s_addr, s_wdata, s_wen, s_ren,
    input  s0_sel, s1_sel, s0_rdata, s1_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m0_gnt, m0_ack, m0_err, m0_rdata,
    input  m1_gnt, m1_ack, m1_err, m1_rdata,
    input  s_addr, s_wdata, s_wen, s_ren,
    output s0_sel, s1_sel, s0_rdata, s1_rdata
  );

endinterface

// File: rtl/dbus_arbiter_rr_arb2.sv
// Two-way round-robin picker.
//   req        : request vector, bit 0 = M0, bit 1 = M1
//   last_grant : master that won the previous grant
//   winner     : master to grant; a lone requester always wins, on a tie
//                the master not granted last wins. Output is don't-care
//                when req is zero.
module rr_arb2
  import dbus_pkg::*;
(
  input  logic [1:0] req,
  input  mid_t       last_grant,
  output mid_t       winner
);

  // Winner selection
  always_comb begin
    winner = M0;
    case (req)
      2'b01:   winner = M0;
      2'b10:   winner = M1;
      2'b11:   winner = (last_grant == M0) ? M1 : M0;
      default: winner = M0;
    endcase
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Arbiter sharing one simple data bus between two masters.
// One transaction in flight: a grant cycle drives the shared bus with the
// winner's request, the following cycle returns ack/err/rdata to that
// master. Continuous requests therefore run at one transaction per two
// cycles, alternating between masters when both are busy.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dbus_arbiter_if.slave (master handshakes + shared bus)
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic           clk,
  input logic           rst_n,
  dbus_arbiter_if.slave bus
);

  state_t            state_r;
  state_t            state_s;
  mid_t              pend_id_r;     // winner chosen on entry to GNT
  mid_t              last_grant_r;
  mid_t              txn_id_r;      // owner of the transaction in RESP
  logic              txn_we_r;
  logic              txn_sel0_r;
  logic              txn_sel1_r;
  mid_t              rr_win_s;
  logic [1:0]        req_s;
  logic              req_any_s;
  logic [DATA_W-1:0] resp_rdata_s;
  logic              resp_err_s;

  assign req_s     = {bus.m1_req, bus.m0_req};
  assign req_any_s = |req_s;

  rr_arb2 u_rr_arb2 (
    .req        (req_s),
    .last_grant (last_grant_r),
    .winner     (rr_win_s)
  );

  // State register and per-transaction bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      pend_id_r    <= M0;
      last_grant_r <= M1;
      txn_id_r     <= M0;
      txn_we_r     <= 1'b0;
      txn_sel0_r   <= 1'b0;
      txn_sel1_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      // Requests are only looked at on the way into GNT; the masters hold
      // their request stable through the grant cycle.
      if ((state_r != ST_GNT) && req_any_s) begin
        pend_id_r <= rr_win_s;
      end
      // The slave hit flags are only meaningful while s_addr is driven,
      // so they are captured at the end of the grant cycle.
      if (state_r == ST_GNT) begin
        last_grant_r <= pend_id_r;
        txn_id_r     <= pend_id_r;
        txn_we_r     <= bus.s_wen;
        txn_sel0_r   <= bus.s0_sel;
        txn_sel1_r   <= bus.s1_sel;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_any_s) state_s = ST_GNT;
        else           state_s = ST_IDLE;
      end
      ST_GNT:  state_s = ST_RESP;
      ST_RESP: begin
        if (req_any_s) state_s = ST_GNT;
        else           state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Response data: exactly one hit selects that slave, anything else is 0
  always_comb begin
    resp_rdata_s = {DATA_W{1'b0}};
    if (txn_we_r) begin
      resp_rdata_s = {DATA_W{1'b0}};
    end else begin
      case ({txn_sel1_r, txn_sel0_r})
        2'b01:   resp_rdata_s = bus.s0_rdata;
        2'b10:   resp_rdata_s = bus.s1_rdata;
        default: resp_rdata_s = {DATA_W{1'b0}};
      endcase
    end
  end

  assign resp_err_s = decode_err(txn_sel0_r, txn_sel1_r);

  // Grant/bus drive in GNT, completion in RESP, everything quiet otherwise
  always_comb begin
    bus.m0_gnt   = 1'b0;
    bus.m1_gnt   = 1'b0;
    bus.m0_ack   = 1'b0;
    bus.m1_ack   = 1'b0;
    bus.m0_err   = 1'b0;
    bus.m1_err   = 1'b0;
    bus.m0_rdata = {DATA_W{1'b0}};
    bus.m1_rdata = {DATA_W{1'b0}};
    bus.s_addr   = {ADDR_W{1'b0}};
    bus.s_wdata  = {DATA_W{1'b0}};
    bus.s_wen    = 1'b0;
    bus.s_ren    = 1'b0;
    case (state_r)
      ST_GNT: begin
        if (pend_id_r == M1) begin
          bus.m1_gnt  = 1'b1;
          bus.s_addr  = bus.m1_addr;
          bus.s_wdata = bus.m1_wdata;
          bus.s_wen   = bus.m1_we;
          bus.s_ren   = ~bus.m1_we;
        end else begin
          bus.m0_gnt  = 1'b1;
          bus.s_addr  = bus.m0_addr;
          bus.s_wdata = bus.m0_wdata;
          bus.s_wen   = bus.m0_we;
          bus.s_ren   = ~bus.m0_we;
        end
      end
      ST_RESP: begin
        if (txn_id_r == M1) begin
          bus.m1_ack   = 1'b1;
          bus.m1_err   = resp_err_s;
          bus.m1_rdata = resp_rdata_s;
        end else begin
          bus.m0_ack   = 1'b1;
          bus.m0_err   = resp_err_s;
          bus.m0_rdata = resp_rdata_s;
        end
      end
      default: begin
        bus.m0_gnt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter: directed scenarios followed by
// randomized master traffic, all compared cycle by cycle against a
// cycle-rule reference model (a cycle is a grant cycle when the previous
// cycle was not and had a request; the cycle after a grant is its ack).
module tb_dbus_arbiter;

  logic clk;
  logic rst_n;

  dbus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dbus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave models: region 0x8/0xB hits slave 0, 0x9/0xB hits slave 1
  function automatic logic dec0(input logic [31:0] a);
    return (a[31:28] == 4'h8) || (a[31:28] == 4'hB);
  endfunction
  function automatic logic dec1(input logic [31:0] a);
    return (a[31:28] == 4'h9) || (a[31:28] == 4'hB);
  endfunction
  function automatic logic [31:0] rd0(input logic [31:0] a);
    return a ^ 32'h5EAD_BEFF;
  endfunction
  function automatic logic [31:0] rd1(input logic [31:0] a);
    return a ^ 32'h0F0F_1234;
  endfunction

  logic [31:0] s0_rd = 32'h0;
  logic [31:0] s1_rd = 32'h0;

  assign bus.s0_sel   = dec0(bus.s_addr);
  assign bus.s1_sel   = dec1(bus.s_addr);
  assign bus.s0_rdata = s0_rd;
  assign bus.s1_rdata = s1_rd;

  always @(posedge clk) begin
    if (bus.s_ren) begin
      s0_rd <= rd0(bus.s_addr);
      s1_rd <= rd1(bus.s_addr);
    end else begin
      s0_rd <= $urandom;
      s1_rd <= $urandom;
    end
  end

  // Master stimulus state
  bit          mreq [2];
  bit          mwe  [2];
  logic [31:0] maddr[2];
  logic [31:0] mwd  [2];

  // Reference model state
  bit          pg;        // previous cycle was a grant cycle
  bit [1:0]    pr;        // requests seen in previous cycle
  bit          lw;        // last winner
  bit          t_id, t_we, t_s0, t_s1;
  logic [31:0] t_addr;
  bit [1:0]    granted;   // who was granted in the cycle just stepped

  // Observations
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  obs_gnt;
  logic        last_err [2];
  logic [31:0] last_rd  [2];
  int          acks     [2];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic apply();
    bus.m0_req = mreq[0]; bus.m0_we = mwe[0]; bus.m0_addr = maddr[0]; bus.m0_wdata = mwd[0];
    bus.m1_req = mreq[1]; bus.m1_we = mwe[1]; bus.m1_addr = maddr[1]; bus.m1_wdata = mwd[1];
  endtask

  task automatic model_reset();
    pg = 1'b0; pr = 2'b00; lw = 1'b1; granted = 2'b00;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_gnt"},    {bus.m1_gnt, bus.m0_gnt}, 64'd0);
    check_eq({tag, "_ack"},    {bus.m1_ack, bus.m0_ack}, 64'd0);
    check_eq({tag, "_err"},    {bus.m1_err, bus.m0_err}, 64'd0);
    check_eq({tag, "_rdata"},  {bus.m1_rdata, bus.m0_rdata}, 64'd0);
    check_eq({tag, "_strobe"}, {bus.s_wen, bus.s_ren}, 64'd0);
    check_eq({tag, "_bus"},    {bus.s_addr, bus.s_wdata}, 64'd0);
  endtask

  // One clock cycle: called just after a rising edge with stimulus set.
  task automatic step();
    bit g, w;
    logic [1:0]  eg, ea, ee, est;
    logic [31:0] er [2];
    logic [31:0] ead, ewd, rd;
    apply();
    g  = !pg && (pr != 2'b00);
    w  = (pr == 2'b11) ? !lw : pr[1];
    eg = 2'b00; est = 2'b00; ead = 32'h0; ewd = 32'h0;
    if (g) begin
      eg[w] = 1'b1;
      ead   = maddr[w];
      ewd   = mwd[w];
      est   = mwe[w] ? 2'b10 : 2'b01;
    end
    ea = 2'b00; ee = 2'b00; er[0] = 32'h0; er[1] = 32'h0;
    if (pg) begin
      ea[t_id] = 1'b1;
      ee[t_id] = (t_s0 == t_s1);
      if (!t_we) begin
        rd = 32'h0;
        if (t_s0 && !t_s1) rd = rd0(t_addr);
        if (t_s1 && !t_s0) rd = rd1(t_addr);
        er[t_id] = rd;
      end
    end
    @(negedge clk);
    check_eq("gnt",    {bus.m1_gnt, bus.m0_gnt}, eg);
    check_eq("ack",    {bus.m1_ack, bus.m0_ack}, ea);
    check_eq("err",    {bus.m1_err, bus.m0_err}, ee);
    check_eq("rdata0", bus.m0_rdata, er[0]);
    check_eq("rdata1", bus.m1_rdata, er[1]);
    check_eq("strobe", {bus.s_wen, bus.s_ren}, est);
    check_eq("s_addr", bus.s_addr, ead);
    check_eq("s_wdata", bus.s_wdata, ewd);
    obs_gnt = {bus.m1_gnt, bus.m0_gnt};
    if (bus.m0_ack) begin acks[0]++; last_err[0] = bus.m0_err; last_rd[0] = bus.m0_rdata; end
    if (bus.m1_ack) begin acks[1]++; last_err[1] = bus.m1_err; last_rd[1] = bus.m1_rdata; end
    granted = 2'b00;
    if (g) begin
      granted[w] = 1'b1;
      lw     = w;
      t_id   = w;
      t_we   = mwe[w];
      t_addr = maddr[w];
      t_s0   = dec0(maddr[w]);
      t_s1   = dec1(maddr[w]);
    end
    pg = g;
    pr = {mreq[1], mreq[0]};
    @(posedge clk); #1;
  endtask

  // Request until granted (bounded), then drop the request for the ack cycle.
  task automatic issue(input int m, input bit we, input logic [31:0] a, input logic [31:0] d);
    bit done;
    mreq[m] = 1'b1; mwe[m] = we; maddr[m] = a; mwd[m] = d;
    done = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      step();
      done = granted[m];
    end
    check_eq("grant_timeout", done, 1'b1);
    mreq[m] = 1'b0;
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mreq[0] = 1'b0; mreq[1] = 1'b0;
    apply();
    model_reset();
    @(posedge clk); #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [3:0] top;
    top = 4'h8 + 4'($urandom_range(0, 3));
    return {top, 28'($urandom) & 28'hFFF_FFFC};
  endfunction

  task automatic random_phase(input int cycles, input int pct);
    bit g, w;
    for (int c = 0; c < cycles; c++) begin
      g = !pg && (pr != 2'b00);
      w = (pr == 2'b11) ? !lw : pr[1];
      for (int i = 0; i < 2; i++) begin
        if (granted[i] || !mreq[i]) begin
          mreq[i] = ($urandom_range(0, 99) < pct);
          if (mreq[i]) begin
            mwe[i] = $urandom_range(0, 1);
            maddr[i] = rand_addr();
            mwd[i] = $urandom;
          end
        end else if (!(g && (w == i)) && ($urandom_range(0, 19) == 0)) begin
          mreq[i] = 1'b0;  // withdraw a request that has not been sampled
        end
      end
      step();
    end
    mreq[0] = 1'b0; mreq[1] = 1'b0;
    step();
    step();
  endtask

  initial begin
    logic [15:0] gv;
    int          a0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mreq[i] = 1'b0; mwe[i] = 1'b0; maddr[i] = 32'h0; mwd[i] = 32'h0;
      acks[i] = 0; last_err[i] = 1'b0; last_rd[i] = 32'h0;
    end
    apply();
    do_reset();

    // M0 read from slave 0
    issue(0, 1'b0, 32'h8000_0010, 32'h0);
    check_eq("m0_read_rdata", last_rd[0], 32'hDEAD_BEEF);
    check_eq("m0_read_err", last_err[0], 1'b0);

    // M1 write to slave 1
    issue(1, 1'b1, 32'h9000_0004, 32'h1234_5678);
    check_eq("m1_write_rdata", last_rd[1], 32'h0);
    check_eq("m1_write_err", last_err[1], 1'b0);

    // Decode errors: no hit, then double hit
    issue(0, 1'b0, 32'hA000_0000, 32'h0);
    check_eq("nohit_err", last_err[0], 1'b1);
    check_eq("nohit_rdata", last_rd[0], 32'h0);
    issue(0, 1'b0, 32'hB000_0008, 32'h0);
    check_eq("dblhit_err", last_err[0], 1'b1);
    check_eq("dblhit_rdata", last_rd[0], 32'h0);

    // Both masters requesting continuously right after reset
    do_reset();
    mreq[0] = 1'b1; mwe[0] = 1'b0; maddr[0] = 32'h8000_0100; mwd[0] = 32'h0;
    mreq[1] = 1'b1; mwe[1] = 1'b1; maddr[1] = 32'h9000_0200; mwd[1] = 32'hCAFE_0001;
    gv = 16'h0;
    for (int c = 0; c < 8; c++) begin
      step();
      gv = {obs_gnt, gv[15:2]};
    end
    check_eq("alternation", gv, 16'h8484);
    mreq[0] = 1'b0; mreq[1] = 1'b0;
    step();
    step();

    // Reset while M0's read is in its ack cycle
    mreq[0] = 1'b1; mwe[0] = 1'b0; maddr[0] = 32'h8000_0020; mwd[0] = 32'h0;
    begin
      bit done;
      done = 1'b0;
      for (int k = 0; k < 8 && !done; k++) begin
        step();
        done = granted[0];
      end
      check_eq("rst_grant_timeout", done, 1'b1);
    end
    mreq[0] = 1'b0; mreq[1] = 1'b0;
    apply();
    #1;
    check_eq("rst_pre_ack", bus.m0_ack, 1'b1);
    a0 = acks[0];
    rst_n = 1'b0;
    #1;
    check_zero("rst_resp");
    @(posedge clk); #1;
    check_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    issue(1, 1'b0, 32'h9000_0040, 32'h0);
    check_eq("rst_no_m0_ack", acks[0], a0);
    check_eq("rst_m1_rdata", last_rd[1], rd1(32'h9000_0040));

    // Randomized traffic at several request densities
    random_phase(300, 30);
    random_phase(300, 80);
    random_phase(300, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of masters and shared bus.
REQ-002 Parameter DATA_W, default 32, data width of masters and shared bus.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 m0_req / m1_req  input  1  transaction request from master 0 (core D-port) / master 1 (loader).
REQ-006 m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-007 m0_addr / m1_addr  input  ADDR_W  byte address.
REQ-008 m0_wdata / m1_wdata  input  DATA_W  write data.
REQ-009 m0_gnt / m1_gnt  output  1  one-cycle grant pulse.
REQ-010 m0_ack / m1_ack  output  1  one-cycle completion pulse.
REQ-011 m0_err / m1_err  output  1  decode error, valid only with ack.
REQ-012 m0_rdata / m1_rdata  output  DATA_W  read data, valid with ack of a read.
REQ-013 s_addr  output  ADDR_W  shared bus address.
REQ-014 s_wdata  output  DATA_W  shared bus write data.
REQ-015 s_wen / s_ren  output  1  shared bus write / read strobe.
REQ-016 s0_sel / s1_sel  input  1  slave address-hit flags, combinational from s_addr.
REQ-017 s0_rdata / s1_rdata  input  DATA_W  slave read data, valid one cycle after s_ren.

Function
REQ-018 FSM states IDLE, GNT, RESP; exactly one transaction in flight.
REQ-019 IDLE: any req -> GNT next cycle; no req -> stay IDLE.
REQ-020 GNT (1 cycle): mX_gnt=1 for winner; s_addr/s_wdata = winner's signals; s_wen=we, s_ren=!we; -> RESP.
REQ-021 Outside GNT: s_wen=s_ren=0, s_addr/s_wdata=0.
REQ-022 End of GNT: register winner id, we, s0_sel, s1_sel.
REQ-023 RESP (1 cycle): mX_ack=1 for registered winner only; -> GNT if any req asserted, else IDLE.
REQ-024 RESP read: rdata = s0_rdata if sel0 only, s1_rdata if sel1 only; else 0.
REQ-025 err=1 with ack when neither or both sel registered; write strobe still issued (slaves gate by own sel).
REQ-026 mX_rdata=0 whenever mX_ack=0 or transaction was a write.
REQ-027 Arbitration: single requester wins; both requesting -> master not granted last wins (round-robin).
REQ-028 last_grant updated only in GNT cycle.
REQ-029 Masters hold req/we/addr/wdata stable until gnt; req sampled in GNT-entry cycle only; deassert before gnt = withdrawn, no error.
REQ-030 Throughput: one transaction per 2 cycles under continuous requests; both masters continuous -> strict alternation M0,M1,M0...
REQ-031 Req asserted in RESP by the just-acked master counts as new request.

Reset
REQ-032 rst_n low: state=IDLE, last_grant=1 (M0 wins first tie), registered sel/we/id=0, all outputs 0, asynchronously.
REQ-033 Reset mid-GNT or mid-RESP: strobes drop immediately; aborted transaction never acked; write may or may not have landed.
REQ-034 After rst_n rises, first grant no earlier than next cycle with req high.

Structure
REQ-035 Shared package dbus_pkg: FSM state enum, master-id constants M0/M1, ADDR_W/DATA_W defaults.
REQ-036 One sub-module rr_arb2: 2-way round-robin picker (req[1:0], last_grant -> winner).
REQ-037 Response mux and FSM in dbus_arbiter top; no other hierarchy.

Verification
REQ-038 M0 read 0x8000_0010, s0_sel=1, s0_rdata=0xDEADBEEF -> m0_gnt cycle 1, s_ren=1, m0_ack cycle 2, m0_rdata=0xDEADBEEF, err=0.
REQ-039 M1 write 0x9000_0004 data 0x1234_5678, s1_sel=1 -> s_wen=1 one cycle with that addr/data; m1_ack next cycle, rdata=0.
REQ-040 Both req every cycle after reset -> grants M0,M1,M0,M1 on cycles 1,3,5,7; no double ack.
REQ-041 M0 read 0xA000_0000, no sel -> m0_ack=1, m0_err=1, m0_rdata=0; both sel -> same err.
REQ-042 rst_n low during RESP of M0 read -> ack never seen, all outputs 0 same cycle, state IDLE; next M1 request granted normally.
